// File: rtl/f3m_pkg.sv
// Shared trit encodings, ALU mode codes, FSM state type and per-trit helpers
// for the serial GF(3^M) ALU.
package f3m_pkg;

    localparam logic [1:0] TRIT_0   = 2'b00;
    localparam logic [1:0] TRIT_1   = 2'b01;
    localparam logic [1:0] TRIT_2   = 2'b10;
    localparam logic [1:0] TRIT_BAD = 2'b11;

    localparam logic [1:0] MODE_NEG  = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Negation in this encoding is a bit swap (1 <-> 2, 0 stays 0).
    function automatic logic [1:0] trit_neg(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    function automatic logic [1:0] trit_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/f3_trit_alu.sv
// Combinational single-trit ALU lane (negate / add / subtract / pass).
// Operand-code checking is present only when F3M_SERIAL_ALU_CHECK_EN is defined.
module f3_trit_alu
    import f3m_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] mode,
    output logic [1:0] c,
    output logic       invalid
);

    always_comb begin
        c       = a;
        invalid = 1'b0;
        case (mode)
            MODE_NEG: c = trit_neg(a);
            MODE_ADD: c = trit_add(a, b);
            MODE_SUB: c = trit_add(a, trit_neg(b));
            default:  c = a;
        endcase
`ifdef F3M_SERIAL_ALU_CHECK_EN
        // B only counts as an operand when the mode actually consumes it.
        invalid = (a == TRIT_BAD) ||
                  (((mode == MODE_ADD) || (mode == MODE_SUB)) && (b == TRIT_BAD));
        if (invalid) begin
            c = TRIT_0;
        end
`endif
    end

endmodule

// File: rtl/f3m_serial_alu.sv
// Serial GF(3^M) element ALU processing P trits per cycle over ceil(M/P) cycles.
// Optional invalid-code detection via macro F3M_SERIAL_ALU_CHECK_EN.
module f3m_serial_alu
    import f3m_pkg::*;
#(
    parameter int unsigned M = 97,
    parameter int unsigned P = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [2*M-1:0] A,
    input  logic [2*M-1:0] B,
    output logic [2*M-1:0] C,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned N  = (M + P - 1) / P;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = 2 * N * P;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]     mode_q, mode_d;
    logic [2*M-1:0] c_d;
    logic [P-1:0][1:0] lane_c;
    logic [P-1:0]   lane_inv;
    logic           last_chunk;

    // Operands are held zero-padded to whole chunks and shifted down each cycle.
    for (genvar j = 0; j < P; j++) begin : g_lane
        f3_trit_alu u_lane (
            .a       (a_q[2*j +: 2]),
            .b       (b_q[2*j +: 2]),
            .mode    (mode_q),
            .c       (lane_c[j]),
            .invalid (lane_inv[j])
        );
    end

    assign last_chunk = (cnt_q == CW'(N - 1));

`ifdef F3M_SERIAL_ALU_CHECK_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    logic unused_inv;
    assign unused_inv = ^lane_inv;
    assign err        = 1'b0;
`endif

    // Next-state, operand capture and chunk write-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        c_d     = C;
`ifdef F3M_SERIAL_ALU_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = SW'(A);
                    b_d     = SW'(B);
                    mode_d  = mode;
`ifdef F3M_SERIAL_ALU_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                // Only trit positions below M exist, so padding lanes never write C.
                for (int unsigned i = 0; i < M; i++) begin
                    if (cnt_q == CW'(i / P)) begin
                        c_d[2*i +: 2] = lane_c[i % P];
`ifdef F3M_SERIAL_ALU_CHECK_EN
                        if (lane_inv[i % P]) begin
                            err_d = 1'b1;
                        end
`endif
                    end
                end
                a_d = a_q >> (2 * P);
                b_d = b_q >> (2 * P);
                if (last_chunk) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            C       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef F3M_SERIAL_ALU_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            C       <= c_d;
            busy    <= (state_d == RUN);
            done    <= (state_d == DONE);
`ifdef F3M_SERIAL_ALU_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: doc/f3m_serial_alu.md
F3M_SERIAL_ALU -- requirements
Module: f3m_serial_alu

Interface
REQ-001 Parameter M, default 97: trits per GF(3^M) element.
REQ-002 Parameter P, default 8: trits processed per cycle (1 <= P <= M).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 mode  input  2  00 C=-A, 01 C=A+B, 10 C=A-B, 11 C=A; sampled with start.
REQ-007 A  input  2*M  operand A; trit i at bits [2i+1:2i].
REQ-008 B  input  2*M  operand B; same packing as A.
REQ-009 C  output  2*M  result register.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 done  output  1  one-cycle pulse; C is valid on the same cycle.
REQ-012 err  output  1  invalid-code flag (see Configuration).

Function
REQ-013 Trit encoding SHALL be 00=0, 01=1, 10=2; per-trit negation SHALL swap the two bits.
REQ-014 Per-trit add SHALL be mod 3; sub SHALL be add of the negated B trit.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch A, B and mode into internal registers, clear the chunk counter and enter RUN.
REQ-017 start while busy=1 SHALL be ignored; A, B and mode changes during RUN SHALL have no effect.
REQ-018 RUN SHALL process chunk k (trits k*P .. k*P+P-1) in cycle k+1 after the start cycle, writing only those trits of C.
REQ-019 N = ceil(M/P) chunks; on the last chunk, lanes with index >= M SHALL be ignored and SHALL NOT write C.
REQ-020 After chunk N-1, FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE unless start=1.
REQ-021 Latency: start sampled at cycle t -> done=1 at cycle t+N+1; busy=1 for cycles t+1 .. t+N.
REQ-022 Back-to-back: start=1 during DONE SHALL begin the next operation, with done=1 for that cycle and RUN next.
REQ-023 C SHALL hold its value from done until the first chunk write of the next operation.
REQ-024 Chunk counter width SHALL be clog2(N) bits minimum; it SHALL NOT wrap within an operation.

Reset
REQ-025 reset=1 SHALL force IDLE, C=0, busy=0, done=0, err=0, counter=0, regardless of state.
REQ-026 reset during RUN SHALL abort the operation with no done pulse; reset SHALL take priority over start.

Configuration
REQ-027 Macro F3M_SERIAL_ALU_CHECK_EN defined: any processed operand trit equal to 11 SHALL set err, sticky until next accepted start or reset; the affected C trit SHALL be written 00.
REQ-028 Macro undefined: err SHALL be tied 0; 11 codes give unspecified C trits; no checking logic is generated.

Structure
REQ-029 Package f3m_pkg SHALL hold trit encoding constants (TRIT_0/1/2), mode constants (MODE_NEG/ADD/SUB/PASS) and the FSM state typedef.
REQ-030 Sub-module f3_trit_alu (combinational: 2-bit a, 2-bit b, mode -> 2-bit c, invalid flag) SHALL be instantiated P times.

Verification (M=5, P=2, N=3)
REQ-031 mode=00, A trits {2,1,0,1,2} -> at t+4 done=1, C trits {1,2,0,2,1}; busy high t+1..t+3.
REQ-032 mode=01, A={1,1,2,2,0}, B={1,2,2,0,1} -> C={2,0,1,2,1}; mode=10 same operands -> C={0,2,0,2,2}.
REQ-033 start held high through RUN with A changed mid-run -> result uses latched A; second start in DONE cycle -> next done exactly 4 cycles later.
REQ-034 reset asserted at t+2 of a run -> no done pulse, C=0 next cycle, busy=0.
REQ-035 With F3M_SERIAL_ALU_CHECK_EN, A trit 2 = 11, mode=11 -> err=1 at done, C trit 2 = 00; next valid start clears err. Without the macro, err stays 0.
REQ-036 Randomised 1000 ops vs. per-trit reference model for M=5/P=2, M=97/P=8, M=7/P=7 -> zero mismatches.
